// File: rtl/usbdev_pkg.sv
// Shared types for the usbdev AON wake sequencer.
package usbdev_pkg;

  typedef enum logic [2:0] {
    AwsIdle   = 3'd0,
    AwsSettle = 3'd1,
    AwsEnter  = 3'd2,
    AwsActive = 3'd3,
    AwsWake   = 3'd4,
    AwsExit   = 3'd5
  } aon_wake_seq_e;

  typedef struct packed {
    logic sense_lost;
    logic bus_reset;
    logic not_idle;
  } aon_wake_cause_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/usbdev_aon_wake_seq.sv
// AON-domain sequencer: suspend entry into the wake detector, pwrmgr wakeup,
// wake-cause capture and link hand-back on software ack.
module usbdev_aon_wake_seq
  import usbdev_pkg::*;
#(
  parameter int unsigned SettleCycles = 4,
  parameter int unsigned EnterTimeout = 16,
  parameter int unsigned ExitTimeout  = 16
) (
  input  logic       clk_aon_i,
  input  logic       rst_aon_ni,
  input  logic       suspend_pls_aon_i,
  input  logic       wake_ack_aon_i,
  input  logic       det_active_aon_i,
  input  logic       det_wake_req_aon_i,
  input  logic       det_not_idle_aon_i,
  input  logic       det_bus_reset_aon_i,
  input  logic       det_sense_lost_aon_i,
  output logic       det_suspend_req_o,
  output logic       det_wake_ack_o,
  output logic       wkup_req_aon_o,
  output logic [2:0] wake_cause_aon_o,
  output logic       err_timeout_aon_o,
  output logic [2:0] state_aon_o
);

  localparam int unsigned CntMax = max3(SettleCycles, EnterTimeout, ExitTimeout);
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] SettleLd = CntW'(SettleCycles - 1);
  localparam logic [CntW-1:0] EnterLd  = CntW'(EnterTimeout - 1);
  localparam logic [CntW-1:0] ExitLd   = CntW'(ExitTimeout - 1);

  aon_wake_seq_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  aon_wake_cause_t cause_q, cause_d;
  logic            sus_req_q, sus_req_d;
  logic            wack_q, wack_d;
  logic            wkup_q, wkup_d;
  logic            err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CntW'(1) : cnt_q;
    cause_d = cause_q;
    err_d   = 1'b0;
    unique case (state_q)
      AwsIdle: begin
        if (suspend_pls_aon_i) begin
          state_d = AwsSettle;
          cnt_d   = SettleLd;
          cause_d = '0;
        end
      end
      AwsSettle: begin
        if (wake_ack_aon_i) begin
          state_d = AwsIdle;
        end else if (cnt_q == '0) begin
          state_d = AwsEnter;
          cnt_d   = EnterLd;
        end
      end
      AwsEnter: begin
        if (det_active_aon_i) begin
          state_d = AwsActive;
        end else if (cnt_q == '0) begin
          state_d = AwsIdle;
          err_d   = 1'b1;
        end
      end
      AwsActive: begin
        // A wake request beats a coincident ack so the cause is never lost.
        if (det_wake_req_aon_i) begin
          state_d = AwsWake;
          cause_d = '{sense_lost: det_sense_lost_aon_i,
                      bus_reset:  det_bus_reset_aon_i,
                      not_idle:   det_not_idle_aon_i};
        end else if (wake_ack_aon_i) begin
          state_d = AwsExit;
          cnt_d   = ExitLd;
        end else if (!det_active_aon_i) begin
          state_d = AwsIdle;
        end
      end
      AwsWake: begin
        if (wake_ack_aon_i) begin
          state_d = AwsExit;
          cnt_d   = ExitLd;
        end
      end
      AwsExit: begin
        if (!det_active_aon_i) begin
          state_d = AwsIdle;
        end else if (cnt_q == '0) begin
          state_d = AwsIdle;
          err_d   = 1'b1;
        end
      end
      default: state_d = AwsIdle;
    endcase
    // Outputs are decoded from the next state so they leave straight from flops.
    sus_req_d = (state_d == AwsEnter);
    wack_d    = (state_d == AwsExit);
    wkup_d    = (state_d == AwsWake);
  end

  always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
    if (!rst_aon_ni) begin
      state_q   <= AwsIdle;
      cnt_q     <= '0;
      cause_q   <= '0;
      sus_req_q <= 1'b0;
      wack_q    <= 1'b0;
      wkup_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      sus_req_q <= sus_req_d;
      wack_q    <= wack_d;
      wkup_q    <= wkup_d;
      err_q     <= err_d;
    end
  end

  assign det_suspend_req_o = sus_req_q;
  assign det_wake_ack_o    = wack_q;
  assign wkup_req_aon_o    = wkup_q;
  assign wake_cause_aon_o  = cause_q;
  assign err_timeout_aon_o = err_q;
  assign state_aon_o       = state_q;

endmodule

// File: tb/tb_usbdev_aon_wake_seq.sv
// Directed + randomized bench for usbdev_aon_wake_seq against an elapsed-cycle reference model.
module tb_usbdev_aon_wake_seq;

  localparam int SETTLE = 4, ENTER_TO = 16, EXIT_TO = 16;
  localparam int S_IDLE = 0, S_SETTLE = 1, S_ENTER = 2, S_ACTIVE = 3, S_WAKE = 4, S_EXIT = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic susp, ack, act, wreq, ni, br, sl;
  logic sreq, wack, wkup, err;
  logic [2:0] cause, state;

  int n_cmp = 0, n_err = 0;

  // reference model: phase, cycles spent in phase, captured cause, error pulse
  int   m_st, m_el;
  logic [2:0] m_cause;
  logic m_err;

  always #5 clk = ~clk;

  usbdev_aon_wake_seq #(.SettleCycles(SETTLE), .EnterTimeout(ENTER_TO), .ExitTimeout(EXIT_TO)) dut (
    .clk_aon_i(clk), .rst_aon_ni(rst_n),
    .suspend_pls_aon_i(susp), .wake_ack_aon_i(ack), .det_active_aon_i(act),
    .det_wake_req_aon_i(wreq), .det_not_idle_aon_i(ni), .det_bus_reset_aon_i(br),
    .det_sense_lost_aon_i(sl),
    .det_suspend_req_o(sreq), .det_wake_ack_o(wack), .wkup_req_aon_o(wkup),
    .wake_cause_aon_o(cause), .err_timeout_aon_o(err), .state_aon_o(state)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic s, a, ac, w, n, b, l);
    susp = s; ack = a; act = ac; wreq = w; ni = n; br = b; sl = l;
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_el = 0; m_cause = 3'b000; m_err = 1'b0;
  endtask

  task automatic model_step();
    m_err = 1'b0;
    case (m_st)
      S_IDLE:   if (susp) begin m_st = S_SETTLE; m_el = 0; m_cause = 3'b000; end
      S_SETTLE: if (ack) m_st = S_IDLE;
                else if (m_el == SETTLE - 1) begin m_st = S_ENTER; m_el = 0; end
                else m_el++;
      S_ENTER:  if (act) m_st = S_ACTIVE;
                else if (m_el == ENTER_TO - 1) begin m_st = S_IDLE; m_err = 1'b1; end
                else m_el++;
      S_ACTIVE: if (wreq) begin m_st = S_WAKE; m_cause = {sl, br, ni}; end
                else if (ack) begin m_st = S_EXIT; m_el = 0; end
                else if (!act) m_st = S_IDLE;
      S_WAKE:   if (ack) begin m_st = S_EXIT; m_el = 0; end
      S_EXIT:   if (!act) m_st = S_IDLE;
                else if (m_el == EXIT_TO - 1) begin m_st = S_IDLE; m_err = 1'b1; end
                else m_el++;
      default:  m_st = S_IDLE;
    endcase
  endtask

  task automatic check_model();
    chk("state", 8'(state), 8'(m_st));
    chk("det_suspend_req", 8'(sreq), 8'(m_st == S_ENTER));
    chk("det_wake_ack", 8'(wack), 8'(m_st == S_EXIT));
    chk("wkup_req", 8'(wkup), 8'(m_st == S_WAKE));
    chk("wake_cause", 8'(cause), 8'(m_cause));
    chk("err_timeout", 8'(err), 8'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    check_model();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sreq"}, 8'(sreq), 8'h0);
    chk({tag, "_wack"}, 8'(wack), 8'h0);
    chk({tag, "_wkup"}, 8'(wkup), 8'h0);
    chk({tag, "_cause"}, 8'(cause), 8'h0);
    chk({tag, "_err"}, 8'(err), 8'h0);
    chk({tag, "_state"}, 8'(state), 8'h0);
  endtask

  // called right after step(): reset is asserted mid-cycle, away from clock edges
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_zero(tag);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic go_active();
    set_in(1, 0, 1, 0, 0, 0, 0); step();
    set_in(0, 0, 1, 0, 0, 0, 0);
    repeat (5) step();
    chk("go_active_state", 8'(state), 8'(S_ACTIVE));
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12 check_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // 1: normal cycle
    set_in(1, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 2; i <= 5; i++) begin
      step();
      chk("t1_sreq_latency", 8'(sreq), 8'(i == 5));
    end
    set_in(0, 0, 1, 0, 0, 0, 0); step();
    chk("t1_active", 8'(state), 8'(S_ACTIVE));
    chk("t1_sreq_drop", 8'(sreq), 8'h0);
    set_in(0, 0, 1, 1, 1, 0, 0); step();
    chk("t1_wkup", 8'(wkup), 8'h1);
    chk("t1_cause", 8'(cause), 8'h1);
    set_in(0, 1, 1, 0, 0, 0, 0); step();
    chk("t1_wack", 8'(wack), 8'h1);
    set_in(0, 0, 0, 0, 0, 0, 0); step();
    chk("t1_idle", 8'(state), 8'(S_IDLE));
    chk("t1_wack_drop", 8'(wack), 8'h0);
    step();

    // 2: enter timeout
    set_in(1, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (4) step();
    for (int i = 0; i < 15; i++) begin
      step();
      chk("t2_in_enter", 8'(state), 8'(S_ENTER));
    end
    step();
    chk("t2_err", 8'(err), 8'h1);
    chk("t2_idle", 8'(state), 8'(S_IDLE));
    chk("t2_sreq", 8'(sreq), 8'h0);
    step();
    chk("t2_err_pulse", 8'(err), 8'h0);

    // 3: simultaneous wake request and ack
    go_active();
    set_in(0, 1, 1, 1, 0, 0, 1); step();
    chk("t3_wake", 8'(state), 8'(S_WAKE));
    chk("t3_cause", 8'(cause), 8'h4);
    set_in(0, 1, 1, 0, 0, 0, 0); step();
    chk("t3_exit", 8'(state), 8'(S_EXIT));
    set_in(0, 0, 0, 0, 0, 0, 0); step();
    chk("t3_cause_sticky", 8'(cause), 8'h4);

    // 4: SETTLE abort
    set_in(1, 0, 0, 0, 0, 0, 0); step();
    chk("t4_cause_clr", 8'(cause), 8'h0);
    set_in(0, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 1, 0, 0, 0, 0, 0); step();
    chk("t4_idle", 8'(state), 8'(S_IDLE));
    chk("t4_no_err", 8'(err), 8'h0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (6) begin
      step();
      chk("t4_sreq_never", 8'(sreq), 8'h0);
    end

    // 5: ignored suspend in ACTIVE, then reset mid-WAKE
    go_active();
    set_in(1, 0, 1, 0, 0, 0, 0); step();
    chk("t5_susp_ignored", 8'(state), 8'(S_ACTIVE));
    set_in(0, 0, 1, 1, 0, 1, 1); step();
    chk("t5_wkup", 8'(wkup), 8'h1);
    set_in(0, 0, 1, 0, 0, 0, 0);
    async_reset("t5_rst");
    set_in(0, 0, 0, 0, 0, 0, 0); step();

    // 6: exit timeout
    go_active();
    set_in(0, 0, 1, 1, 1, 1, 0); step();
    set_in(0, 1, 1, 0, 0, 0, 0); step();
    set_in(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("t6_in_exit", 8'(wack), 8'h1);
    end
    step();
    chk("t6_err", 8'(err), 8'h1);
    chk("t6_idle", 8'(state), 8'(S_IDLE));
    chk("t6_wack", 8'(wack), 8'h0);

    // randomized traffic, biased by the model phase to reach deep states
    for (int c = 0; c < 1500; c++) begin
      logic s, a, ac, w;
      s  = ($urandom_range(0, 3) == 0);
      a  = ($urandom_range(0, 9) == 0);
      ac = $urandom_range(0, 1);
      w  = 1'b0;
      case (m_st)
        S_ENTER:  ac = ($urandom_range(0, 19) != 0);
        S_ACTIVE: begin
          ac = ($urandom_range(0, 19) != 0);
          w  = ($urandom_range(0, 4) == 0);
          a  = ($urandom_range(0, 6) == 0);
        end
        S_WAKE:   a  = ($urandom_range(0, 1) == 0);
        S_EXIT:   ac = ($urandom_range(0, 9) != 0);
        default:  ;
      endcase
      set_in(s, a, ac, w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      step();
      if ($urandom_range(0, 299) == 0) async_reset("rnd_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
